// File: rtl/tpu_pkg.sv
// Shared TPU front-end definitions: operand sizing, compute-window timing, loader states.
// The loader's optional checksum byte is enabled with the CHECKSUM_EN macro.
package tpu_pkg;

  localparam int DATA_W      = 8;
  localparam int N_ELEMS     = 4;
  localparam int N_BYTES     = 2 * N_ELEMS;
  localparam int COMPUTE_LEN = 6;
  localparam int DONE_FIRST  = 2;
  localparam int DONE_LAST   = 5;
  localparam int IDX_W       = 4;
  localparam int CC_W        = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOAD    = 2'd1,
    CHECK   = 2'd2,
    COMPUTE = 2'd3
  } state_e;

  // Result index presented to the feeder: counts 0.. across its done window.
  function automatic logic [1:0] sel_for_cycle(input logic [CC_W-1:0] cc);
    if (cc >= CC_W'(DONE_FIRST) && cc <= CC_W'(DONE_LAST))
      return 2'(cc - CC_W'(DONE_FIRST));
    return 2'd0;
  endfunction

endpackage

// File: rtl/host_byte_sink.sv
// Host byte acceptance: ready/valid transfer, byte index counter and, with CHECKSUM_EN,
// the running XOR of the operand bytes plus the compare against the trailing checksum byte.
module host_byte_sink
  import tpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              accept_en,
  input  logic              host_valid,
`ifdef CHECKSUM_EN
  input  logic [DATA_W-1:0] host_data,
  output logic              csum_ok,
`endif
  output logic              host_ready,
  output logic              wr_en,
  output logic [IDX_W-1:0]  wr_idx,
  output logic              last_byte
);

  // Handshake: host_ready mirrors accept_en; a byte moves on a rising edge with
  // host_valid && host_ready, and the host must hold host_data while host_ready is low.
  logic [IDX_W-1:0] idx;

  assign host_ready = accept_en;
  assign wr_en      = host_valid && accept_en;
  assign wr_idx     = idx;
  assign last_byte  = wr_en && (idx == IDX_W'(N_BYTES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (wr_en) begin
`ifdef CHECKSUM_EN
      if (idx == IDX_W'(N_BYTES))
        idx <= '0;
      else
        idx <= idx + IDX_W'(1);
`else
      if (last_byte)
        idx <= '0;
      else
        idx <= idx + IDX_W'(1);
`endif
    end
  end

`ifdef CHECKSUM_EN
  logic [DATA_W-1:0] xacc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      xacc <= '0;
    end else if (wr_en && (idx < IDX_W'(N_BYTES))) begin
      xacc <= (idx == '0) ? host_data : (xacc ^ host_data);
    end
  end

  assign csum_ok = (xacc == host_data);
`endif

endmodule

// File: rtl/host_loader.sv
// Host-side loader: fills the 2x2 weight/input operand registers from the host byte
// stream, then sequences the feeder (en/compute_cycles/output_sel). CHECKSUM_EN adds a check byte.
module host_loader
  import tpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              host_valid,
  input  logic [DATA_W-1:0] host_data,
  output logic              host_ready,
  output logic [DATA_W-1:0] weight0,
  output logic [DATA_W-1:0] weight1,
  output logic [DATA_W-1:0] weight2,
  output logic [DATA_W-1:0] weight3,
  output logic [DATA_W-1:0] input0,
  output logic [DATA_W-1:0] input1,
  output logic [DATA_W-1:0] input2,
  output logic [DATA_W-1:0] input3,
  output logic              en,
  output logic [CC_W-1:0]   compute_cycles,
  output logic [1:0]        output_sel,
  output logic              busy,
  output logic              load_err,
  output logic [1:0]        state_dbg
);

  localparam logic [1:0]      ST_IDLE    = IDLE;
  localparam logic [1:0]      ST_LOAD    = LOAD;
  localparam logic [1:0]      ST_CHECK   = CHECK;
  localparam logic [1:0]      ST_COMPUTE = COMPUTE;
  localparam logic [CC_W-1:0] LAST_CC    = CC_W'(COMPUTE_LEN - 1);
  localparam int              SEL_W      = $clog2(N_BYTES);

  logic [1:0]        state;
  logic              accept_en;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_idx;
  logic              last_byte;
  logic [DATA_W-1:0] opnd [N_BYTES];
`ifdef CHECKSUM_EN
  logic              csum_ok;
  logic              err_q;
`endif

`ifdef CHECKSUM_EN
  assign accept_en = (state == ST_IDLE) || (state == ST_LOAD) || (state == ST_CHECK);
`else
  assign accept_en = (state == ST_IDLE) || (state == ST_LOAD);
`endif

  host_byte_sink u_sink (
    .clk        (clk),
    .rst_n      (rst_n),
    .accept_en  (accept_en),
    .host_valid (host_valid),
`ifdef CHECKSUM_EN
    .host_data  (host_data),
    .csum_ok    (csum_ok),
`endif
    .host_ready (host_ready),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .last_byte  (last_byte)
  );

  // Operand file: indices 0-3 are weights, 4-7 are inputs; the check byte (index 8) is not stored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_BYTES; k++) opnd[k] <= '0;
    end else if (wr_en && (wr_idx < IDX_W'(N_BYTES))) begin
      opnd[wr_idx[SEL_W-1:0]] <= host_data;
    end
  end

  assign weight0 = opnd[0];
  assign weight1 = opnd[1];
  assign weight2 = opnd[2];
  assign weight3 = opnd[3];
  assign input0  = opnd[4];
  assign input1  = opnd[5];
  assign input2  = opnd[6];
  assign input3  = opnd[7];

  // COMPUTE spends one entry cycle with en low, then COMPUTE_LEN cycles with en high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= ST_IDLE;
      en             <= 1'b0;
      compute_cycles <= '0;
      busy           <= 1'b0;
`ifdef CHECKSUM_EN
      err_q          <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (wr_en) begin
            busy  <= 1'b1;
            state <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          if (last_byte) begin
`ifdef CHECKSUM_EN
            state <= ST_CHECK;
`else
            state <= ST_COMPUTE;
`endif
          end
        end
        ST_CHECK: begin
`ifdef CHECKSUM_EN
          if (wr_en) begin
            if (csum_ok) begin
              err_q <= 1'b0;
              state <= ST_COMPUTE;
            end else begin
              err_q <= 1'b1;
              busy  <= 1'b0;
              state <= ST_IDLE;
            end
          end
`else
          busy  <= 1'b0;
          state <= ST_IDLE;
`endif
        end
        ST_COMPUTE: begin
          if (!en) begin
            en             <= 1'b1;
            compute_cycles <= '0;
          end else if (compute_cycles == LAST_CC) begin
            en             <= 1'b0;
            compute_cycles <= '0;
            busy           <= 1'b0;
            state          <= ST_IDLE;
          end else begin
            compute_cycles <= compute_cycles + CC_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign output_sel = sel_for_cycle(compute_cycles);
  assign state_dbg  = state;

`ifdef CHECKSUM_EN
  assign load_err = err_q;
`else
  assign load_err = 1'b0;
`endif

endmodule

// File: tb/tb_host_loader.sv
// Bench for host_loader: stream-level reference model (expected operand file plus the
// fixed compute window timing), directed and random streams; covers CHECKSUM_EN when defined.
module tb_host_loader;
  import tpu_pkg::*;

`ifdef CHECKSUM_EN
  localparam int NB = 9;
`else
  localparam int NB = 8;
`endif

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       host_valid = 1'b0;
  logic [7:0] host_data = 8'h00;

  always #5 clk = ~clk;

  logic       host_ready, en, busy, load_err;
  logic [7:0] weight0, weight1, weight2, weight3;
  logic [7:0] input0, input1, input2, input3;
  logic [3:0] compute_cycles;
  logic [1:0] output_sel, state_dbg;

  host_loader dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .host_valid     (host_valid),
    .host_data      (host_data),
    .host_ready     (host_ready),
    .weight0        (weight0),
    .weight1        (weight1),
    .weight2        (weight2),
    .weight3        (weight3),
    .input0         (input0),
    .input1         (input1),
    .input2         (input2),
    .input3         (input3),
    .en             (en),
    .compute_cycles (compute_cycles),
    .output_sel     (output_sel),
    .busy           (busy),
    .load_err       (load_err),
    .state_dbg      (state_dbg)
  );

  logic [7:0] act [8];
  always_comb begin
    act[0] = weight0; act[1] = weight1; act[2] = weight2; act[3] = weight3;
    act[4] = input0;  act[5] = input1;  act[6] = input2;  act[7] = input3;
  end

  // ---------------- scoreboard / model state ----------------
  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_reg [8];
  logic [7:0] exp_q [$];
  logic       exp_err = 1'b0;
  logic [7:0] stim [9];

  int   cyc = 0;
  int   en_rise_cyc = 0;
  int   en_fall_cyc = 0;
  logic en_d = 1'b0;

  always @(negedge clk) begin
    cyc  <= cyc + 1;
    en_d <= en;
    if (en && !en_d) en_rise_cyc <= cyc;
    if (!en && en_d) en_fall_cyc <= cyc;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic check_regs(input string tag);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s_reg%0d", tag, k), 32'(act[k]), 32'(exp_reg[k]));
  endtask

  task automatic check_final();
    for (int k = 0; k < 8; k++) begin
      logic [7:0] e;
      e = exp_q.pop_front();
      check($sformatf("final_reg%0d", k), 32'(act[k]), 32'(e));
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 8; k++) exp_reg[k] = 8'h00;
    exp_q.delete();
    exp_err = 1'b0;
  endtask

  // ---------------- driver tasks ----------------
  task automatic fill_stim(input bit rnd);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < 8; i++) begin
      stim[i] = rnd ? 8'($urandom) : 8'(i + 1);
      x = x ^ stim[i];
    end
    stim[8] = x;
  endtask

  // Presents stim[start..stop-1]; every cycle of the load phase must show host_ready high.
  task automatic load_stream(input int start, input int stop, input int stall_at,
                             input int stall_len, input bit rnd_stall);
    for (int i = start; i < stop; i++) begin
      int s;
      s = rnd_stall ? int'($urandom_range(0, 2)) : ((i == stall_at) ? stall_len : 0);
      for (int j = 0; j < s; j++) begin
        host_valid = 1'b0;
        host_data  = 8'($urandom);
        check("ready_stall", 32'(host_ready), 32'(1));
        check_regs("stall");
        @(negedge clk);
      end
      host_valid = 1'b1;
      host_data  = stim[i];
      check("ready_load", 32'(host_ready), 32'(1));
      check("busy_load", 32'(busy), 32'(i > 0));
      @(negedge clk);
      if (i < 8) begin
        exp_reg[i] = stim[i];
        exp_q.push_back(stim[i]);
      end
      check_regs("load");
    end
    host_valid = 1'b0;
  endtask

  // Called on the first negedge after the final accepted byte.
  task automatic expect_compute();
    for (int c = 0; c <= COMPUTE_LEN; c++) begin
      int k, es;
      k  = c - 1;
      es = (k >= 2 && k <= 5) ? k - 2 : 0;
      check("cmp_en", 32'(en), 32'(c > 0));
      check("cmp_cc", 32'(compute_cycles), 32'((c > 0) ? k : 0));
      check("cmp_sel", 32'(output_sel), 32'(es));
      check("cmp_ready", 32'(host_ready), 32'(0));
      check("cmp_busy", 32'(busy), 32'(1));
      check_regs("cmp");
      @(negedge clk);
    end
    check("end_en", 32'(en), 32'(0));
    check("end_cc", 32'(compute_cycles), 32'(0));
    check("end_sel", 32'(output_sel), 32'(0));
    check("end_busy", 32'(busy), 32'(0));
    check("end_ready", 32'(host_ready), 32'(1));
    check("end_state", 32'(state_dbg), 32'(IDLE));
    check("end_err", 32'(load_err), 32'(exp_err));
  endtask

  task automatic check_all_zero(input string tag);
    for (int k = 0; k < 8; k++)
      check($sformatf("%s_reg%0d", tag, k), 32'(act[k]), 32'(0));
    check({tag, "_en"}, 32'(en), 32'(0));
    check({tag, "_cc"}, 32'(compute_cycles), 32'(0));
    check({tag, "_sel"}, 32'(output_sel), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_err"}, 32'(load_err), 32'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  // ---------------- test sequence ----------------
  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_ready", 32'(host_ready), 32'(1));
    check("rst_state", 32'(state_dbg), 32'(IDLE));

    // basic load 1..8
    fill_stim(1'b0);
    load_stream(0, NB, -1, 0, 1'b0);
    expect_compute();
    check("basic_w0", 32'(weight0), 32'(1));
    check("basic_i3", 32'(input3), 32'(8));
    check_final();

    // random contents so the stall test below overwrites distinct values
    fill_stim(1'b1);
    load_stream(0, NB, -1, 0, 1'b1);
    expect_compute();
    check_final();

    // stalled host: valid low for 3 cycles after the third byte
    fill_stim(1'b0);
    load_stream(0, NB, 3, 3, 1'b0);
    expect_compute();
    check_final();

    // backpressure: 0xFF held during COMPUTE, taken as weight0 on the first IDLE cycle
    fill_stim(1'b1);
    load_stream(0, NB, -1, 0, 1'b0);
    host_valid = 1'b1;
    host_data  = 8'hFF;
    expect_compute();
    check_final();
    @(negedge clk);
    exp_reg[0] = 8'hFF;
    exp_q.push_back(8'hFF);
    check("bp_w0", 32'(weight0), 32'(8'hFF));
    check("bp_busy", 32'(busy), 32'(1));
    fill_stim(1'b1);
    stim[8] = stim[8] ^ stim[0] ^ 8'hFF;
    stim[0] = 8'hFF;
    load_stream(1, NB, -1, 0, 1'b0);
    expect_compute();
    check_final();

    // back-to-back: next stream begins right at IDLE; en gap is 9 cycles
    fill_stim(1'b1);
    load_stream(0, NB, -1, 0, 1'b0);
    begin
      int fall1;
      fall1 = en_fall_cyc;
      expect_compute();
      check("b2b_gap", 32'(en_rise_cyc - fall1), 32'(9));
    end
    check_final();

    // reset mid-stream after byte 5, outputs clear before the next edge
    fill_stim(1'b1);
    load_stream(0, 5, -1, 0, 1'b0);
    #2 rst_n = 1'b0;
    #1 check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    check("midrst_ready", 32'(host_ready), 32'(1));
    fill_stim(1'b1);
    load_stream(0, NB, -1, 0, 1'b1);
    expect_compute();
    check_final();

    // randomized streams with random stalls
    for (int r = 0; r < 4; r++) begin
      fill_stim(1'b1);
      load_stream(0, NB, -1, 0, 1'b1);
      expect_compute();
      check_final();
    end

`ifdef CHECKSUM_EN
    // good checksum: 1..8 xor = 0x08
    fill_stim(1'b0);
    check("csum_value", 32'(stim[8]), 32'(8'h08));
    load_stream(0, NB, -1, 0, 1'b0);
    expect_compute();
    check_final();

    // bad checksum: error flagged, no compute, back to IDLE
    fill_stim(1'b0);
    stim[8] = 8'h00;
    load_stream(0, NB, -1, 0, 1'b0);
    exp_err = 1'b1;
    for (int c = 0; c < 10; c++) begin
      check("bad_en", 32'(en), 32'(0));
      check("bad_err", 32'(load_err), 32'(1));
      check("bad_busy", 32'(busy), 32'(0));
      check("bad_state", 32'(state_dbg), 32'(IDLE));
      check("bad_ready", 32'(host_ready), 32'(1));
      @(negedge clk);
    end
    check_final();

    // a following good stream clears the error
    exp_err = 1'b0;
    fill_stim(1'b1);
    load_stream(0, NB, -1, 0, 1'b1);
    expect_compute();
    check_final();
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/host_loader.md
Name: host_loader

Overview:
- Host-side front end of the TPU datapath: accepts a byte stream from the RPi and fills the 2x2 weight and input operand registers.
- After the stream completes, drives the feeder's en/compute_cycles/output_sel sequencing, then returns to idle for the next matrix pair.
- Sits between the host byte interface and mmu_feeder. It is the writer/controller end of the operand interface that the feeder reads.

Parameters:
- DATA_W, 8, operand byte width
- N_ELEMS, 4, elements per matrix (2x2)
- COMPUTE_LEN, 6, cycles en is held high; compute_cycles runs 0..COMPUTE_LEN-1

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- host_valid  in  1  host presents a byte on host_data
- host_data  in  8  operand byte, order w0,w1,w2,w3,i0,i1,i2,i3
- host_ready  out  1  loader accepts a byte this cycle
- weight0..weight3  out  8 each  registered weight operands to feeder
- input0..input3  out  8 each  registered input operands to feeder
- en  out  1  feeder enable
- compute_cycles  out  4  feeder phase counter
- output_sel  out  2  feeder result index
- busy  out  1  high from first accepted byte until return to IDLE
- load_err  out  1  sticky checksum error (only with CHECKSUM_EN; otherwise tied 0)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; all operand regs, en, compute_cycles, output_sel, busy and load_err go to 0.
  - host_ready is decoded from state, so it reads 1 once rst_n deasserts.
- Transfer rule: a byte transfers on a rising edge where host_valid && host_ready. host_data is ignored otherwise.
- IDLE: host_ready=1. A transfer writes weight0, sets idx=1 and busy=1, and moves to LOAD.
- LOAD: host_ready=1.
  - Each transfer writes the register selected by idx: 0-3 go to weight0-3, 4-7 go to input0-3. idx then increments.
  - The transfer with idx=7 moves to COMPUTE (or CHECK when CHECKSUM_EN is defined).
  - host_valid low stalls indefinitely. There is no timeout.
- COMPUTE: host_ready=0.
  - Next cycle en=1 and compute_cycles=0. compute_cycles then increments by 1 per cycle up to COMPUTE_LEN-1.
  - The cycle after compute_cycles reaches COMPUTE_LEN-1: en=0, compute_cycles=0, busy=0, state=IDLE.
- output_sel = compute_cycles-2 (low 2 bits) while compute_cycles is in 2..5, else 0. This aligns with the feeder's done window.
- Operand registers hold their values through COMPUTE and until overwritten by the next stream.
- Bytes presented while host_ready=0 are not consumed. The host must hold them.
- Reset mid-load or mid-compute: immediate return to reset values. The partial stream is discarded.
- An idx counter wraparound past 7 cannot occur; it is always cleared on entry to IDLE.

Optional Feature:
- Macro CHECKSUM_EN.
- Defined:
  - The stream carries a 9th byte equal to the XOR of the 8 operand bytes.
  - A CHECK state accepts this byte with host_ready=1.
  - On match, go to COMPUTE.
  - On mismatch, set load_err=1 (sticky until reset or the next successful check), clear busy, and return to IDLE without asserting en.
- Undefined: 8-byte stream, no CHECK state, load_err tied 0.

Decomposition:
- Shared package tpu_pkg:
  - state enum {IDLE, LOAD, CHECK, COMPUTE}
  - DATA_W, N_ELEMS, COMPUTE_LEN
  - DONE_FIRST=2, DONE_LAST=5 (the feeder's done window)
- One natural sub-module: host_byte_sink. It holds the valid/ready acceptance, the idx counter and the running XOR. It outputs wr_en, wr_idx and last_byte to the parent FSM, which owns the operand register file and the compute sequencer.

Test Plan:
- Basic load: stream 1,2,3,4,5,6,7,8 with host_valid held high.
  - weight0..3=1..4 and input0..3=5..8 after 8 edges.
  - en high for exactly 6 cycles with compute_cycles 0..5.
  - output_sel 0,1,2,3 during compute_cycles 2..5.
- Stalled host: deassert host_valid for 3 cycles after byte 3.
  - idx holds and no register changes.
  - Final operand values are identical to the basic load.
- Backpressure: host_valid high during COMPUTE with data 0xFF.
  - host_ready=0 and no operand changes.
  - The byte is accepted as the new weight0 on the first IDLE cycle.
- Reset mid-stream: rst_n low after byte 5.
  - All outputs 0 asynchronously (before the next clock edge).
  - A fresh 8-byte stream then loads correctly.
- Back-to-back: a second stream starts immediately after return to IDLE.
  - The second en pulse begins 9 cycles after the first ends (8 load cycles plus one entry cycle).
- CHECKSUM_EN: stream 1..8 with checksum 0x08 gives a normal compute.
  - The same stream with checksum 0x00 gives load_err=1, en never high, busy=0, and the FSM back in IDLE.
